cell_probe: RTL and testbench
=============================

CELL_PROBE -- requirements
Module: cell_probe

Interface
REQ-001 SHALL have parameter PAGE_W, default 6: width of the cell page and cell input words.
REQ-002 SHALL have parameter CNT_W, default 16: edge-count result width, 9..16.
REQ-003 SHALL have parameter GATE_LOG2, default 10: measurement window is 2^GATE_LOG2 clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port in, input, `INPUT_BITS (at least 9): bit 0 command strobe, bit 1 mode, bits 7:2 switches, bit 8 result byte select.
REQ-007 SHALL have port out, output, `OUTPUT_BITS (at least 10): bits 7:0 data, bit 8 busy, bit 9 overflow, all higher bits 0.

Function
REQ-008 SHALL pass in[0] through a 2-flop synchroniser; a command executes on the cycle after its synchronised rising edge.
REQ-009 SHALL pass in[1] and in[8:2] through 2-flop synchronisers.
REQ-010 SHALL, on a command with mode=0, load cm_in with the switches.
REQ-011 SHALL, on a command with mode=1 and switches[5:3]!=3'b111, load cm_page with the switches, abort any measurement to IDLE, and set view to cells.
REQ-012 SHALL, on a command with mode=1 and switches[5:3]==3'b111, set sel to switches[2:0], set view to counter, and enter ARM from any state; a measurement in progress restarts.
REQ-013 SHALL drive probe = cm_out[sel], re-synchronised through 2 flops, with rising-edge detect.
REQ-014 SHALL use FSM states IDLE, ARM, COUNT and DONE.
REQ-015 ARM SHALL last 1 cycle, clear the gate counter, the live count and ovf_live, then go to COUNT.
REQ-016 COUNT SHALL last exactly 2^GATE_LOG2 cycles, add 1 per detected probe rising edge, and go to DONE.
REQ-017 The live count SHALL saturate at all-ones; an edge arriving at saturation SHALL set ovf_live.
REQ-018 On the COUNT-to-DONE transition the result and ovf registers SHALL load from the live count and ovf_live.
REQ-019 DONE SHALL hold until the next command.
REQ-020 A page command during COUNT SHALL leave result and ovf unchanged.
REQ-021 busy SHALL be 1 in ARM and COUNT, and 0 otherwise.
REQ-022 out[7:0] SHALL be cm_out when view is cells; otherwise result[7:0] when in[8]=0, or result[CNT_W-1:8] zero-extended when in[8]=1.
REQ-023 cm_out SHALL come from the existing cell_mux instance, driven by cm_page and cm_in.

Reset
REQ-024 Asserting rst_n low SHALL asynchronously clear cm_page, cm_in, sel, all synchronisers, the counters, result and ovf; set the FSM to IDLE and view to cells; out is then cm_out of page 0 with input 0, busy 0 and ovf 0.
REQ-025 Reset during COUNT SHALL discard the measurement; no result is retained.

Configuration
REQ-026 With CELL_PROBE_CONTINUOUS_EN defined, DONE SHALL go to ARM after 1 cycle, re-measuring indefinitely; busy SHALL read 1 throughout and result SHALL update once per window.
REQ-027 Without CELL_PROBE_CONTINUOUS_EN, DONE SHALL be terminal as in REQ-019.

Structure
REQ-028 The shared package SHALL hold the FSM state enum, the MEAS_PREFIX constant 3'b111, and the in/out bit-position constants.
REQ-029 The edge detector, gate counter and saturating counter SHALL be one sub-module, edge_gate_counter, parameterised by CNT_W and GATE_LOG2.
REQ-030 cell_mux SHALL be reused unchanged.

Verification (cell_mux stub: page 0 gives out={2'b00,in}; GATE_LOG2=8, CNT_W=16)
REQ-031 Reset with rst_n low mid-COUNT -> out[9:8]=0 and FSM IDLE immediately, with no clk edge needed.
REQ-032 Measure command 111000, then 10 probe rising edges via mode-0 strobes toggling switch bit 0 inside the window -> busy for 257 cycles, then out[7:0]=10, ovf=0.
REQ-033 With CNT_W=9, 600 edges in the window -> result 511 and ovf=1; with in[8]=1, out[7:0]=1.
REQ-034 Page command 000001 during COUNT -> immediate IDLE, busy=0, view cells, result register unchanged.
REQ-035 A second measure command issued mid-COUNT -> window restarts, and the count covers only the edges after the restart.
REQ-036 With CELL_PROBE_CONTINUOUS_EN, a constant 3 edges per window -> result=3 after each window, and a new value is loaded every 258 cycles.

Source files
------------

// File: rtl/cell_probe_pkg.sv
// Shared types and bit positions for the cell probe.
`ifndef INPUT_BITS
`define INPUT_BITS 9
`endif
`ifndef OUTPUT_BITS
`define OUTPUT_BITS 10
`endif

package cell_probe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] MEAS_PREFIX = 3'b111;

   localparam int unsigned IN_BITS  = `INPUT_BITS;
   localparam int unsigned OUT_BITS = `OUTPUT_BITS;

   localparam int unsigned IN_STB   = 0;
   localparam int unsigned IN_MODE  = 1;
   localparam int unsigned IN_SW_LO = 2;
   localparam int unsigned IN_SW_HI = 7;
   localparam int unsigned IN_BSEL  = 8;
   localparam int unsigned SW_W     = IN_SW_HI - IN_SW_LO + 1;

   localparam int unsigned OUT_BUSY = 8;
   localparam int unsigned OUT_OVF  = 9;

endpackage

// File: rtl/cell_mux.sv
// Cell multiplexer: page 0 passes the input through, other pages XOR it with the page.
module cell_mux #(
   parameter int unsigned PAGE_W = 6
) (
   input  logic [PAGE_W-1:0] page,
   input  logic [PAGE_W-1:0] in,
   output logic [PAGE_W-1:0] out
);

   assign out = (page == '0) ? in : (in ^ page);

endmodule

// File: rtl/cell_probe_edge_gate_counter.sv
// Probe rising-edge detector, gate-window counter and saturating edge counter.
module edge_gate_counter #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned GATE_LOG2 = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             probe,
   input  logic             clear,
   input  logic             enable,
   output logic             gate_last_c,
   output logic [CNT_W-1:0] count,
   output logic             ovf_live
);

   logic                 probe_q;
   logic                 rise_c;
   logic [GATE_LOG2-1:0] gate;

   assign rise_c      = probe & ~probe_q;
   assign gate_last_c = enable & (gate == '1);

   // Previous probe level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) probe_q <= 1'b0;
      else        probe_q <= probe;
   end

   // Window counter plus edge count that sticks at all-ones and flags overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate     <= '0;
         count    <= '0;
         ovf_live <= 1'b0;
      end else if (clear) begin
         gate     <= '0;
         count    <= '0;
         ovf_live <= 1'b0;
      end else if (enable) begin
         gate <= gate + GATE_LOG2'(1);
         if (rise_c) begin
            if (count == '1) ovf_live <= 1'b1;
            else             count    <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cell_probe.sv
// Cell probe: drives a cell_mux page/input from switch commands and counts
// rising edges of one selected cell output over a 2^GATE_LOG2-cycle window.
// Define CELL_PROBE_CONTINUOUS_EN to re-arm automatically after every window.
module cell_probe
   import cell_probe_pkg::*;
#(
   parameter int unsigned PAGE_W    = 6,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned GATE_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_BITS-1:0]  in,
   output logic [OUT_BITS-1:0] out
);

`ifdef CELL_PROBE_CONTINUOUS_EN
   localparam logic DONE_BUSY = 1'b1;
`else
   localparam logic DONE_BUSY = 1'b0;
`endif

   logic                stb_s1, stb_s2, stb_s3;
   logic [IN_BITS-1:1]  ctl_s1, ctl_s2;
   logic                cmd_c, mode_c, bsel_c, meas_c;
   logic [SW_W-1:0]     sw_c;

   state_t              state;
   logic                busy, view_cnt, ovf;
   logic [2:0]          sel;
   logic [PAGE_W-1:0]   cm_page, cm_in, cm_out;
   logic [7:0]          cm_pad;
   logic                probe_s1, probe_s2;
   logic [CNT_W-1:0]    result, count;
   logic                ovf_live, gate_last_c;

   assign cmd_c  = stb_s2 & ~stb_s3;
   assign mode_c = ctl_s2[IN_MODE];
   assign bsel_c = ctl_s2[IN_BSEL];
   assign sw_c   = ctl_s2[IN_SW_HI:IN_SW_LO];
   assign meas_c = (sw_c[SW_W-1 -: 3] == MEAS_PREFIX);
   assign cm_pad = 8'(cm_out);

   cell_mux #(.PAGE_W(PAGE_W)) u_cell_mux (
      .page (cm_page),
      .in   (cm_in),
      .out  (cm_out)
   );

   edge_gate_counter #(.CNT_W(CNT_W), .GATE_LOG2(GATE_LOG2)) u_egc (
      .clk         (clk),
      .rst_n       (rst_n),
      .probe       (probe_s2),
      .clear       (state == ST_ARM),
      .enable      (state == ST_COUNT),
      .gate_last_c (gate_last_c),
      .count       (count),
      .ovf_live    (ovf_live)
   );

   // Two-flop synchronisers for the command inputs and the selected probe cell
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stb_s1   <= 1'b0;
         stb_s2   <= 1'b0;
         stb_s3   <= 1'b0;
         ctl_s1   <= '0;
         ctl_s2   <= '0;
         probe_s1 <= 1'b0;
         probe_s2 <= 1'b0;
      end else begin
         stb_s1   <= in[IN_STB];
         stb_s2   <= stb_s1;
         stb_s3   <= stb_s2;
         ctl_s1   <= in[IN_BITS-1:1];
         ctl_s2   <= ctl_s1;
         probe_s1 <= cm_pad[sel];
         probe_s2 <= probe_s1;
      end
   end

   // Command decode and measurement FSM; commands override the window sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         view_cnt <= 1'b0;
         sel      <= '0;
         cm_page  <= '0;
         cm_in    <= '0;
         result   <= '0;
         ovf      <= 1'b0;
      end else begin
         if (cmd_c && !mode_c) cm_in <= PAGE_W'(sw_c);

         if (cmd_c && mode_c && !meas_c) begin
            cm_page  <= PAGE_W'(sw_c);
            view_cnt <= 1'b0;
            state    <= ST_IDLE;
            busy     <= 1'b0;
         end else if (cmd_c && mode_c) begin
            sel      <= sw_c[2:0];
            view_cnt <= 1'b1;
            state    <= ST_ARM;
            busy     <= 1'b1;
         end else begin
            case (state)
               ST_ARM: begin
                  state <= ST_COUNT;
                  busy  <= 1'b1;
               end
               ST_COUNT: begin
                  if (gate_last_c) begin
                     state  <= ST_DONE;
                     busy   <= DONE_BUSY;
                     result <= count;
                     ovf    <= ovf_live;
                  end
               end
               ST_DONE: begin
`ifdef CELL_PROBE_CONTINUOUS_EN
                  state <= ST_ARM;
                  busy  <= 1'b1;
`else
                  state <= ST_DONE;
`endif
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Output view: cell outputs or the selected result byte, plus status bits
   always_comb begin
      out = '0;
      if (!view_cnt)   out[7:0] = cm_pad;
      else if (!bsel_c) out[7:0] = result[7:0];
      else             out[7:0] = 8'(result >> 8);
      out[OUT_BUSY] = busy;
      out[OUT_OVF]  = ovf;
   end

endmodule

// File: tb/tb_cell_probe.sv
// Directed bench for cell_probe: two instances share one stimulus bus
// (A: CNT_W=16, GATE_LOG2=8; B: CNT_W=9, long window for saturation).
`timescale 1ns/1ps
module tb_cell_probe;
   import cell_probe_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [IN_BITS-1:0]  stim;
   logic [OUT_BITS-1:0] out_a, out_b;

   always #5 clk = ~clk;

   cell_probe #(.PAGE_W(6), .CNT_W(16), .GATE_LOG2(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .in(stim), .out(out_a));

   cell_probe #(.PAGE_W(6), .CNT_W(9), .GATE_LOG2(14)) dut_b (
      .clk(clk), .rst_n(rst_n), .in(stim), .out(out_b));

   typedef struct {
      logic [7:0] data;
      logic       ovf;
   } exp_t;

   exp_t   sb_a[$];
   exp_t   sb_b[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     span_a = 0, last_span_a = 0;
   int     busy_run = 0, last_busy_run = 0;
   int     done_at_a[$];
   state_t prev_a = ST_IDLE;

   always @(posedge clk) cyc <= cyc + 1;

   // Observer: window length (ARM..COUNT), busy run length, DONE entry times
   always @(negedge clk) begin
      if (dut_a.state == ST_ARM) span_a = 1;
      else if (dut_a.state == ST_COUNT) span_a++;
      if (dut_a.state == ST_DONE && prev_a == ST_COUNT) begin
         last_span_a = span_a;
         done_at_a.push_back(cyc);
      end
      prev_a = dut_a.state;
      if (out_a[OUT_BUSY]) busy_run++;
      else begin
         if (busy_run != 0) last_busy_run = busy_run;
         busy_run = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic mode, input logic [5:0] sw);
      stim[IN_MODE] = mode;
      stim[IN_SW_HI:IN_SW_LO] = sw;
      @(negedge clk);
      stim[IN_STB] = 1'b1;
      repeat (3) @(negedge clk);
      stim[IN_STB] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic toggle_edges(input int n);
      for (int i = 0; i < n; i++) begin
         cmd(1'b0, 6'b000001);
         cmd(1'b0, 6'b000000);
      end
   endtask

   task automatic wait_st(input bit b, input state_t s, input int bound, input string tag);
      int n = 0;
      while (((b ? dut_b.state : dut_a.state) != s) && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_reached"}, 32'((b ? dut_b.state : dut_a.state) == s), 32'd1);
   endtask

   task automatic wait_done(input bit b, input int bound, input string tag);
      wait_st(b, ST_DONE, bound, tag);
      @(negedge clk);
   endtask

   task automatic pop_chk(input bit b, input string tag);
      exp_t                e;
      logic [OUT_BITS-1:0] o;
      int                  sz;
      o  = b ? out_b : out_a;
      sz = b ? sb_b.size() : sb_a.size();
      chk({tag, "_sb_size"}, 32'(sz), 32'd1);
      if (sz > 0) begin
         e = b ? sb_b.pop_front() : sb_a.pop_front();
         chk({tag, "_data"}, 32'(o[7:0]), 32'(e.data));
         chk({tag, "_ovf"}, 32'(o[OUT_OVF]), 32'(e.ovf));
      end
   endtask

   initial begin
      stim  = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_a", 32'(out_a), 32'd0);
      chk("rst_out_b", 32'(out_b), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Page 0 passes the cell input straight through
      cmd(1'b0, 6'b101101);
      chk("pass_p0", 32'(out_a[7:0]), 32'h2D);
      cmd(1'b0, 6'b000000);

      // Empty window: length and terminal DONE
      cmd(1'b1, 6'b111000);
      sb_a.push_back('{data: 8'd0, ovf: 1'b0});
      wait_done(1'b0, 400, "win0");
      pop_chk(1'b0, "win0");
      chk("arm_to_done", 32'(last_span_a), 32'd257);
`ifndef CELL_PROBE_CONTINUOUS_EN
      repeat (20) @(negedge clk);
      chk("done_hold_busy", 32'(out_a[OUT_BUSY]), 32'd0);
      chk("done_hold_state", 32'(dut_a.state == ST_DONE), 32'd1);
      chk("busy_len", 32'(last_busy_run), 32'd257);
`else
      chk("cont_busy", 32'(out_a[OUT_BUSY]), 32'd1);
`endif
      cmd(1'b1, 6'b000000);

      // Ten probe edges inside one window
      cmd(1'b1, 6'b111000);
      sb_a.push_back('{data: 8'd10, ovf: 1'b0});
      toggle_edges(10);
      wait_done(1'b0, 400, "ten");
      pop_chk(1'b0, "ten");
      stim[IN_BSEL] = 1'b1;
      repeat (4) @(negedge clk);
      chk("hi_byte16", 32'(out_a[7:0]), 32'd0);
      stim[IN_BSEL] = 1'b0;
      repeat (4) @(negedge clk);
      chk("lo_byte16", 32'(out_a[7:0]), 32'd10);
      cmd(1'b1, 6'b000000);

      // Page command aborts a running window without touching the result
      cmd(1'b1, 6'b111000);
      repeat (20) @(negedge clk);
      chk("pre_abort_busy", 32'(out_a[OUT_BUSY]), 32'd1);
      chk("during_count_result", 32'(out_a[7:0]), 32'd10);
      cmd(1'b1, 6'b000001);
      chk("abort_busy", 32'(out_a[OUT_BUSY]), 32'd0);
      chk("abort_state", 32'(dut_a.state == ST_IDLE), 32'd1);
      chk("abort_view", 32'(out_a[7:0]), 32'h01);
      cmd(1'b1, 6'b111000);
      sb_a.push_back('{data: 8'd0, ovf: 1'b0});
      repeat (5) @(negedge clk);
      chk("result_kept", 32'(out_a[7:0]), 32'd10);
      wait_done(1'b0, 400, "after_abort");
      pop_chk(1'b0, "after_abort");
      cmd(1'b1, 6'b000000);

      // Second measure command restarts the window
      cmd(1'b1, 6'b111000);
      toggle_edges(5);
      cmd(1'b1, 6'b111000);
      sb_a.push_back('{data: 8'd3, ovf: 1'b0});
      toggle_edges(3);
      wait_done(1'b0, 400, "restart");
      pop_chk(1'b0, "restart");
      cmd(1'b1, 6'b000000);

      // Asynchronous reset in the middle of a window
      cmd(1'b1, 6'b111000);
      repeat (20) @(negedge clk);
      chk("pre_rst_busy", 32'(out_a[OUT_BUSY]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_status", 32'(out_a[9:8]), 32'd0);
      chk("rst_async_state", 32'(dut_a.state == ST_IDLE), 32'd1);
      chk("rst_async_view", 32'(out_a[7:0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cmd(1'b1, 6'b111000);
      repeat (3) @(negedge clk);
      chk("rst_no_result", 32'(out_a[7:0]), 32'd0);
      cmd(1'b1, 6'b000000);

`ifdef CELL_PROBE_CONTINUOUS_EN
      // Continuous re-measurement with three edges per window
      cmd(1'b1, 6'b111000);
      done_at_a.delete();
      for (int w = 0; w < 3; w++) begin
         sb_a.push_back('{data: 8'd3, ovf: 1'b0});
         wait_st(1'b0, ST_ARM, 300, "cont_arm");
         @(negedge clk);
         toggle_edges(3);
         wait_done(1'b0, 300, "cont_win");
         pop_chk(1'b0, "cont_win");
      end
      chk("cont_done_count", 32'(done_at_a.size()), 32'd4);
      if (done_at_a.size() == 4) begin
         for (int k = 1; k < 4; k++)
            chk("cont_period", 32'(done_at_a[k] - done_at_a[k-1]), 32'd258);
      end
      cmd(1'b1, 6'b000000);
`endif

      // Saturation and overflow on the 9-bit counter
      cmd(1'b1, 6'b111000);
      sb_b.push_back('{data: 8'hFF, ovf: 1'b1});
      toggle_edges(600);
      wait_done(1'b1, 20000, "ovf");
      pop_chk(1'b1, "ovf");
      stim[IN_BSEL] = 1'b1;
      repeat (4) @(negedge clk);
      chk("ovf_hi_byte", 32'(out_b[7:0]), 32'd1);
      stim[IN_BSEL] = 1'b0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
